// File: rtl/fx_pt_pkg.sv
// Shared helpers for the fixed-point adder/subtractor family.
//   FX_MAX(a,b)    : width macro, larger of two integer expressions
//   fx_max()       : same as FX_MAX, usable in localparam expressions
//   fx_sat_pos(w)  : most positive w-bit two's complement value (0111..1)
//   fx_sat_neg(w)  : most negative w-bit two's complement value (1000..0)
// Both saturation helpers return 64 bits; callers keep the low w bits.
`ifndef FX_MAX
`define FX_MAX(a, b) (((a) > (b)) ? (a) : (b))
`endif

package fx_pt_pkg;

  function automatic int fx_max(input int a, input int b);
    if (a > b) begin
      fx_max = a;
    end else begin
      fx_max = b;
    end
  endfunction

  function automatic logic [63:0] fx_sat_pos(input int w);
    fx_sat_pos = (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] fx_sat_neg(input int w);
    fx_sat_neg = ~fx_sat_pos(w);
  endfunction

endpackage

// File: rtl/fx_pt_rnd_sat.sv
// Combinational round-half-up and saturate.
// Reduces a signed value with IFW fraction bits to OIW.OFW format.
//   val : IW-bit two's complement input, IFW fraction bits
//   res : OIW+OFW-bit rounded and saturated result, OFW fraction bits
//   ovf : res was clamped to a range limit
module fx_pt_rnd_sat
  import fx_pt_pkg::*;
#(
  parameter int IW  = 22,
  parameter int IFW = 10,
  parameter int OIW = 12,
  parameter int OFW = 8
) (
  input  logic [IW-1:0]      val,
  output logic [OIW+OFW-1:0] res,
  output logic               ovf
);

  localparam int OW = OIW + OFW;
  // Rounded value carries one guard integer bit so the +half add cannot wrap.
  localparam int RW = IW + 1 + OFW - IFW;

  logic [RW-1:0] rnd;

  generate
    if (OFW < IFW) begin : g_round
      localparam int SH = IFW - OFW;
      localparam logic [IW:0] HALF = {{IW{1'b0}}, 1'b1} << (SH - 1);
      logic [IW:0] ext;
      logic        unused_lo;
      // Adding half an output LSB then dropping the low bits is an
      // arithmetic shift that rounds ties toward +inf.
      assign ext       = {val[IW-1], val} + HALF;
      assign rnd       = ext[IW:SH];
      assign unused_lo = ^ext[SH-1:0];
    end else if (OFW == IFW) begin : g_same
      assign rnd = {val[IW-1], val};
    end else begin : g_pad
      assign rnd = {val[IW-1], val, {(OFW - IFW){1'b0}}};
    end
  endgenerate

  generate
    if (RW >= OW) begin : g_sat
      localparam logic [63:0] POS = fx_sat_pos(OW);
      localparam logic [63:0] NEG = fx_sat_neg(OW);
      logic [RW-OW:0] hi;
      logic           fits;
      // Value fits when every bit from the output sign upward agrees.
      assign hi   = rnd[RW-1:OW-1];
      assign fits = (&hi) | ~(|hi);

      // Pass through, or clamp toward the side given by the true sign.
      always_comb begin
        if (fits) begin
          res = rnd[OW-1:0];
          ovf = 1'b0;
        end else if (rnd[RW-1]) begin
          res = NEG[OW-1:0];
          ovf = 1'b1;
        end else begin
          res = POS[OW-1:0];
          ovf = 1'b1;
        end
      end
    end else begin : g_ext
      assign res = {{(OW - RW){rnd[RW-1]}}, rnd};
      assign ovf = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/fx_pt_sub_rnd_pipe.sv
// Three-stage handshaked signed fixed-point subtractor: diff = in_a - in_b.
//   clk, rst        : rising-edge clock, asynchronous active-low reset
//   in_a / in_b     : minuend AIW.AFW, subtrahend BIW.BFW (two's complement)
//   in_vld / in_rdy : input handshake; in_rdy is the global stage enable
//   diff / ovf      : DIW.DFW rounded, saturated result and clamp flag
//   out_vld/out_rdy : output handshake
// S1 holds the operands, S2 the exact aligned difference, S3 the rounded
// and saturated result. All stages advance together when the output slot
// is empty or being drained, so nothing is lost or duplicated.
module fx_pt_sub_rnd_pipe
  import fx_pt_pkg::*;
#(
  parameter int AIW = 11,
  parameter int AFW = 9,
  parameter int BIW = 8,
  parameter int BFW = 10,
  parameter int DIW = (AIW > BIW) ? AIW + 1 : BIW + 1,
  parameter int DFW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AIW+AFW-1:0]   in_a,
  input  logic [BIW+BFW-1:0]   in_b,
  input  logic                 in_vld,
  output logic                 in_rdy,
  output logic [DIW+DFW-1:0]   diff,
  output logic                 ovf,
  output logic                 out_vld,
  input  logic                 out_rdy
);

  localparam int MFW = fx_max(AFW, BFW);
  localparam int MIW = fx_max(AIW, BIW) + 1;
  localparam int MW  = MIW + MFW;

  logic                      en;
  logic                      s1_vld;
  logic signed [AIW+AFW-1:0] s1_a;
  logic signed [BIW+BFW-1:0] s1_b;
  logic signed [MW-1:0]      a_ext;
  logic signed [MW-1:0]      b_ext;
  logic signed [MW-1:0]      a_al;
  logic signed [MW-1:0]      b_al;
  logic signed [MW-1:0]      sub;
  logic                      s2_vld;
  logic [MW-1:0]             s2_diff;
  logic [DIW+DFW-1:0]        rs_res;
  logic                      rs_ovf;

  // A held result blocks the whole pipe; in_rdy follows out_rdy combinationally.
  assign en     = ~out_vld | out_rdy;
  assign in_rdy = en;

  // S1: capture the operand pair.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld <= 1'b0;
      s1_a   <= '0;
      s1_b   <= '0;
    end else if (en) begin
      s1_vld <= in_vld;
      if (in_vld) begin
        s1_a <= in_a;
        s1_b <= in_b;
      end
    end
  end

  // Sign-extend to MIW integer bits, then shift up to MFW fraction bits.
  // MIW has one spare integer bit, so the subtraction is exact.
  assign a_ext = MW'(s1_a);
  assign b_ext = MW'(s1_b);
  assign a_al  = a_ext <<< (MFW - AFW);
  assign b_al  = b_ext <<< (MFW - BFW);
  assign sub   = a_al - b_al;

  // S2: register the exact difference.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_vld  <= 1'b0;
      s2_diff <= '0;
    end else if (en) begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_diff <= sub;
      end
    end
  end

  fx_pt_rnd_sat #(
    .IW  (MW),
    .IFW (MFW),
    .OIW (DIW),
    .OFW (DFW)
  ) u_rnd_sat (
    .val (s2_diff),
    .res (rs_res),
    .ovf (rs_ovf)
  );

  // S3: register the output; bubbles leave diff/ovf untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_vld <= 1'b0;
      diff    <= '0;
      ovf     <= 1'b0;
    end else if (en) begin
      out_vld <= s2_vld;
      if (s2_vld) begin
        diff <= rs_res;
        ovf  <= rs_ovf;
      end
    end
  end

endmodule
